// File: rtl/wide_add_seq.sv
// Word-serial W-bit add/sub sequencer; one 33-bit slice, carry chained LSW first.
// Optional CARRY_IN_EN adds a cin port for ADC/SBB semantics.
module wide_add_seq #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2,
  localparam int W = 32 * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
`ifdef CARRY_IN_EN
  input  logic         cin,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         OF,
  output logic         CF,
  output logic         SF,
  output logic         ZF,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     c_q;
  logic [IDX_W-1:0] idx_q;
  logic             op_q;
  logic             carry_q;
  logic             zacc_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             of_q;
  logic             cf_q;
  logic             sf_q;
  logic             zf_q;

  logic [31:0]      a_w;
  logic [31:0]      b_w;
  logic [32:0]      sum33_d;
  logic             last_d;
  logic             init_carry_d;

  // Current word slice through the single 33-bit adder.
  always_comb begin
    a_w     = a_q[idx_q*32 +: 32];
    b_w     = b_q[idx_q*32 +: 32];
    sum33_d = {1'b0, a_w} + {1'b0, b_w}
            + {32'd0, carry_q};
    last_d  = (idx_q == IDX_W'(WORDS - 1));
`ifdef CARRY_IN_EN
    init_carry_d = op ^ cin;
`else
    init_carry_d = op;
`endif
  end

  // Sequencer FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      idx_q       <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      sf_q        <= 1'b0;
      zf_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= op ? ~b : b;
            op_q       <= op;
            carry_q    <= init_carry_d;
            idx_q      <= '0;
            c_q        <= '0;
            zacc_q     <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          c_q[idx_q*32 +: 32] <= sum33_d[31:0];
          carry_q <= sum33_d[32];
          zacc_q  <= zacc_q & (sum33_d[31:0] == 32'd0);
          if (last_d) begin
            of_q <= (a_w[31] == b_w[31])
                 && (sum33_d[31] != a_w[31]);
            sf_q <= sum33_d[31];
            cf_q <= op_q ? ~sum33_d[32] : sum33_d[32];
            zf_q <= zacc_q & (sum33_d[31:0] == 32'd0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign c         = c_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign SF        = sf_q;
  assign ZF        = zf_q;

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs WORDS×32-bit add/subtract by driving one internal 33-bit adder slice over the operand words, LSW first, chaining the carry between words.
- Produces the full-width result plus OF/CF/SF/ZF with the same flag meanings as the team's 32-bit adder.
- Sits between the instruction issue stage and the writeback stage.
- Uses a valid/ready handshake on both sides.

Parameters:
- WORDS, 4, number of 32-bit words per operand (≥2); full width W = 32*WORDS.
- IDX_W, 2, width of the word index counter; must satisfy 2^IDX_W ≥ WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  sequencer can accept a new operation.
- op  input  1  0 = add (a+b), 1 = sub (a−b).
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- c  output  W  result.
- OF  output  1  signed overflow.
- CF  output  1  carry out for add; borrow for sub.
- SF  output  1  c[W-1].
- ZF  output  1  c == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, idx=0, carry=0, in_ready=1, out_valid=0, busy=0.
  - c=0, OF=0, CF=0, SF=0, ZF=0.
  - Reset mid-operation aborts; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b and op; b_eff = op ? ~b : b; carry = op; idx=0; c=0; go to RUN.
  - in_ready=0 from the next cycle.
- RUN, one word per cycle:
  - sum33 = a[idx] + b_eff[idx] + carry.
  - c[idx] = sum33[31:0]; carry = sum33[32]; ZF accumulator = zacc & (sum33[31:0]==0).
  - When idx==WORDS-1: finalize flags and go to DONE. Otherwise idx++.
- Flag finalization, taken from the top word:
  - OF = (a_top[31]==b_eff_top[31]) && (c_top[31]!=a_top[31]).
  - SF = c_top[31].
  - CF = op ? ~carry : carry.
  - ZF = accumulated zero of all words.
- Latency: acceptance edge E0; words computed at edges E1..E(WORDS); out_valid=1 after edge E(WORDS). With WORDS=4, out_valid rises 4 cycles after acceptance.
- DONE:
  - out_valid=1; c and flags held stable until out_valid&&out_ready.
  - On acceptance: go to IDLE; out_valid=0 and in_ready=1 on the next cycle.
  - No same-cycle overlap of result acceptance and new input acceptance; minimum issue interval is WORDS+2 cycles.
- c and flags:
  - Change only in RUN.
  - Intermediate values in c are not guaranteed meaningful while out_valid=0.
  - Flags are updated only at finalization.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; the operands are not queued.
  - out_ready while out_valid=0 has no effect.
- Wrap-around: results are modulo 2^W; carry/borrow is reported only through CF.

Optional Feature:
- Macro CARRY_IN_EN.
- When defined: adds input port cin (1 bit), sampled at acceptance.
  - Initial carry = op ? ~cin : cin, giving ADC (a+b+cin) and SBB (a−b−cin) semantics.
  - CF/OF rules are unchanged.
- When undefined: no cin port; initial carry = op (plain add/sub).

Test Plan:
- Reset mid-RUN: assert rst_n=0 for one edge after 2 words → next cycle out_valid=0, in_ready=1, c=0, all flags 0; a new op then completes normally.
- Add carry chain, WORDS=4: a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1 → out_valid 4 cycles after acceptance; c=0x0000_0001_0000_0000_0000_0000_0000_0000; CF=0, OF=0, ZF=0, SF=0.
- Full wrap: a=all-ones, b=1, op=0 → c=0, CF=1, ZF=1, SF=0, OF=0.
- Sub borrow and signed overflow:
  - a=0, b=1, op=1 → c=all-ones, CF=1, SF=1, ZF=0, OF=0.
  - a=0x8000…0, b=1, op=1 → c=0x7FFF…F, OF=1, CF=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → c and flags stable, in_ready=0, and a pulsed in_valid is ignored. Raise out_ready → next cycle out_valid=0, in_ready=1.
- CARRY_IN_EN:
  - a=5, b=3, op=0, cin=1 → c=9.
  - a=5, b=3, op=1, cin=1 → c=1, CF=0.
